nand_seq_engine: RTL

- Parametrised NAND bus sequencer, successor to the fixed single-target controller.
- Executes one host transaction per request: CMD1, 0-5 address bytes, optional CMD2, optional ready/busy (RB) wait with timeout, then a write or read data burst.
- Supports multiple chip enables and programmable strobe timing.
- Sits between the host request logic and the NAND pins; IO tristate is resolved at top level from io_out/io_oe.

---
 rtl/nand_seq_engine.sv | 350 +++++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/nand_seq_engine.sv
// NAND bus sequencer: CMD1, 0-5 address bytes, optional CMD2, optional ready/busy wait, then a data burst.
// Every output comes from a flop whose next value is decoded from the next state and phase.
module nand_seq_engine #(
  parameter  int DATA_W     = 8,
  parameter  int NUM_CE     = 2,
  parameter  int LEN_W      = 12,
  parameter  int T_WP       = 2,
  parameter  int T_WH       = 1,
  parameter  int T_WB       = 4,
  parameter  int RB_TIMEOUT = 1024,
  localparam int CE_W       = (NUM_CE > 1) ? $clog2(NUM_CE) : 1
) (
  input  logic              SYSCLK,
  input  logic              SYSRESET,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [CE_W-1:0]   req_ce,
  input  logic [7:0]        req_cmd1,
  input  logic              req_has_cmd2,
  input  logic [7:0]        req_cmd2,
  input  logic [2:0]        req_naddr,
  input  logic [39:0]       req_addr,
  input  logic              req_wait_rb,
  input  logic              req_dir,
  input  logic [LEN_W-1:0]  req_len,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              done,
  output logic              err,
  output logic              busy,
  input  logic              wp_en,
  output logic [NUM_CE-1:0] nCE,
  output logic              CLE,
  output logic              ALE,
  output logic              nWE,
  output logic              nRE,
  output logic              nWP,
  output logic [DATA_W-1:0] io_out,
  output logic              io_oe,
  input  logic [DATA_W-1:0] io_in,
  input  logic              RB
);

  localparam int PH_W  = $clog2(T_WP + T_WH + 1);
  localparam int CNT_W = $clog2(RB_TIMEOUT + T_WB + 1);
  localparam logic [PH_W-1:0]  PH_STROBE_END = PH_W'(T_WP - 1);
  localparam logic [PH_W-1:0]  PH_LAST       = PH_W'(T_WP + T_WH - 1);
  localparam logic [PH_W-1:0]  PH_WAIT       = PH_W'(T_WP + T_WH);
  localparam logic [CNT_W-1:0] WB_LAST       = CNT_W'(T_WB - 1);
  localparam logic [CNT_W-1:0] TO_LAST       = CNT_W'(RB_TIMEOUT - 1);

  typedef enum logic [3:0] {
    IDLE, CS_SETUP, CMD1, ADDR, CMD2, WB, WAIT_RB, WDATA, RDATA, FINISH
  } state_t;

  state_t state_q, state_d;
  logic [PH_W-1:0]   ph_q, ph_d;
  logic [2:0]        idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [LEN_W-1:0]  rem_q, rem_d;

  logic [CE_W-1:0]   ce_q, ce_d;
  logic [7:0]        cmd1_q, cmd1_d;
  logic [7:0]        cmd2_q, cmd2_d;
  logic              has_cmd2_q, has_cmd2_d;
  logic [2:0]        naddr_q, naddr_d;
  logic [39:0]       addr_q, addr_d;
  logic              wait_rb_q, wait_rb_d;
  logic              dir_q, dir_d;

  logic              req_ready_q, req_ready_d;
  logic              wr_ready_q, wr_ready_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic [NUM_CE-1:0] nce_q, nce_d;
  logic              cle_q, cle_d;
  logic              ale_q, ale_d;
  logic              nwe_q, nwe_d;
  logic              nre_q, nre_d;
  logic              nwp_q, nwp_d;
  logic [DATA_W-1:0] io_out_q, io_out_d;
  logic              io_oe_q, io_oe_d;

  logic              accept;
  logic [NUM_CE-1:0] ce_hit;
  state_t            data_state, post_state, after_addr;
  logic [PH_W-1:0]   data_ph;
  logic [7:0]        addr_byte;
  logic              active;

  assign accept = req_valid && req_ready_q;

  // Request fields are captured once per transaction; the address count saturates at 5.
  always_comb begin
    ce_d       = ce_q;
    cmd1_d     = cmd1_q;
    cmd2_d     = cmd2_q;
    has_cmd2_d = has_cmd2_q;
    naddr_d    = naddr_q;
    addr_d     = addr_q;
    wait_rb_d  = wait_rb_q;
    dir_d      = dir_q;
    if (accept) begin
      ce_d       = req_ce;
      cmd1_d     = req_cmd1;
      cmd2_d     = req_cmd2;
      has_cmd2_d = req_has_cmd2;
      naddr_d    = (req_naddr > 3'd5) ? 3'd5 : req_naddr;
      addr_d     = req_addr;
      wait_rb_d  = req_wait_rb;
      dir_d      = req_dir;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CE; gi++) begin : g_ce_dec
      assign ce_hit[gi] = (ce_d == CE_W'(gi));
    end
  endgenerate

  always_comb begin
    if (rem_q == '0)  data_state = FINISH;
    else if (dir_q)   data_state = RDATA;
    else              data_state = WDATA;
    data_ph    = dir_q ? '0 : PH_WAIT;
    post_state = wait_rb_q ? WB : data_state;
    after_addr = has_cmd2_q ? CMD2 : post_state;
  end

  always_comb begin
    state_d    = state_q;
    ph_d       = ph_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    err_d      = err_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    io_out_d   = io_out_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          err_d   = 1'b0;
          rem_d   = req_len;
          state_d = CS_SETUP;
        end
      end
      CS_SETUP: begin
        state_d = CMD1;
        ph_d    = '0;
      end
      CMD1: begin
        if (ph_q == PH_LAST) begin
          idx_d   = '0;
          cnt_d   = '0;
          state_d = (naddr_q != 3'd0) ? ADDR : after_addr;
          ph_d    = (state_d == ADDR || state_d == CMD2) ? '0 : data_ph;
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      ADDR: begin
        if (ph_q == PH_LAST) begin
          cnt_d = '0;
          if (idx_q == naddr_q - 3'd1) begin
            state_d = after_addr;
            ph_d    = (state_d == CMD2) ? '0 : data_ph;
          end else begin
            idx_d = idx_q + 3'd1;
            ph_d  = '0;
          end
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      CMD2: begin
        if (ph_q == PH_LAST) begin
          cnt_d   = '0;
          state_d = post_state;
          ph_d    = data_ph;
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      WB: begin
        if (cnt_q == WB_LAST) begin
          cnt_d   = '0;
          state_d = WAIT_RB;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_RB: begin
        // RB is checked before the timeout so a rise on the final cycle still counts as ready.
        if (RB) begin
          state_d = data_state;
          ph_d    = data_ph;
        end else if (cnt_q == TO_LAST) begin
          err_d   = 1'b1;
          state_d = FINISH;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WDATA: begin
        if (ph_q == PH_WAIT) begin
          if (wr_valid && wr_ready_q) begin
            io_out_d = wr_data;
            ph_d     = '0;
          end
        end else if (ph_q == PH_LAST) begin
          rem_d = rem_q - 1'b1;
          if (rem_q == LEN_W'(1)) state_d = FINISH;
          else                    ph_d    = PH_WAIT;
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      RDATA: begin
        if (ph_q == PH_STROBE_END) begin
          rd_data_d  = io_in;
          rd_valid_d = 1'b1;
        end
        if (ph_q == PH_LAST) begin
          rem_d = rem_q - 1'b1;
          ph_d  = '0;
          if (rem_q == LEN_W'(1)) state_d = FINISH;
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    addr_byte = 8'(addr_q >> {idx_d, 3'b000});
    case (state_d)
      CMD1:    io_out_d = DATA_W'(cmd1_q);
      ADDR:    io_out_d = DATA_W'(addr_byte);
      CMD2:    io_out_d = DATA_W'(cmd2_q);
      default: io_out_d = io_out_d;
    endcase

    active      = !(state_d inside {IDLE, FINISH});
    nce_d       = active ? ~ce_hit : '1;
    cle_d       = (state_d == CMD1) || (state_d == CMD2);
    ale_d       = (state_d == ADDR);
    io_oe_d     = (state_d inside {CMD1, ADDR, CMD2, WDATA});
    nwe_d       = 1'b1;
    if ((state_d inside {CMD1, ADDR, CMD2}) || (state_d == WDATA && ph_d != PH_WAIT))
      nwe_d = (ph_d > PH_STROBE_END);
    nre_d       = !(state_d == RDATA && ph_d <= PH_STROBE_END);
    wr_ready_d  = (state_d == WDATA) && (ph_d == PH_WAIT);
    busy_d      = active;
    done_d      = (state_d == FINISH);
    req_ready_d = (state_d == IDLE);
    nwp_d       = ~wp_en;
  end

  always_ff @(posedge SYSCLK) begin
    if (SYSRESET) begin
      state_q     <= IDLE;
      ph_q        <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      rem_q       <= '0;
      ce_q        <= '0;
      cmd1_q      <= '0;
      cmd2_q      <= '0;
      has_cmd2_q  <= 1'b0;
      naddr_q     <= '0;
      addr_q      <= '0;
      wait_rb_q   <= 1'b0;
      dir_q       <= 1'b0;
      req_ready_q <= 1'b1;
      wr_ready_q  <= 1'b0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      nce_q       <= '1;
      cle_q       <= 1'b0;
      ale_q       <= 1'b0;
      nwe_q       <= 1'b1;
      nre_q       <= 1'b1;
      nwp_q       <= 1'b0;
      io_out_q    <= '0;
      io_oe_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      ph_q        <= ph_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      ce_q        <= ce_d;
      cmd1_q      <= cmd1_d;
      cmd2_q      <= cmd2_d;
      has_cmd2_q  <= has_cmd2_d;
      naddr_q     <= naddr_d;
      addr_q      <= addr_d;
      wait_rb_q   <= wait_rb_d;
      dir_q       <= dir_d;
      req_ready_q <= req_ready_d;
      wr_ready_q  <= wr_ready_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      done_q      <= done_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      nce_q       <= nce_d;
      cle_q       <= cle_d;
      ale_q       <= ale_d;
      nwe_q       <= nwe_d;
      nre_q       <= nre_d;
      nwp_q       <= nwp_d;
      io_out_q    <= io_out_d;
      io_oe_q     <= io_oe_d;
    end
  end

  assign req_ready = req_ready_q;
  assign wr_ready  = wr_ready_q;
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign done      = done_q;
  assign err       = err_q;
  assign busy      = busy_q;
  assign nCE       = nce_q;
  assign CLE       = cle_q;
  assign ALE       = ale_q;
  assign nWE       = nwe_q;
  assign nRE       = nre_q;
  assign nWP       = nwp_q;
  assign io_out    = io_out_q;
  assign io_oe     = io_oe_q;

endmodule
